// File: rtl/prng_p2s_if.sv
// prng_p2s_if: word handshake plus serial-line status for the PRNG parallel-to-serial converter.
interface prng_p2s_if;
  logic        load;
  logic [31:0] din;
  logic        ready;
  logic        txd;
  logic        busy;
  logic        word_done;

  modport master (
    output load,
    output din,
    input  ready,
    input  txd,
    input  busy,
    input  word_done
  );

  modport slave (
    input  load,
    input  din,
    output ready,
    output txd,
    output busy,
    output word_done
  );
endinterface

// File: rtl/prng_p2s.sv
// prng_p2s: buffers one 32-bit word and sends it as four UART-style byte frames, LSB first.
// Optional feature macro P2S_PARITY_EN inserts an even-parity bit after each data byte.
module prng_p2s #(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic      clk,
  input  logic      rst,
  prng_p2s_if.slave bus
);

  localparam int            BW        = $clog2(CLKS_PER_BIT);
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
  localparam logic [BW-1:0] BAUD_ONE  = BW'(1'b1);
  localparam logic [BW-1:0] BAUD_ZERO = {BW{1'b0}};

`ifdef P2S_PARITY_EN
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;
`else
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_DATA  = 3'd2,
    ST_STOP  = 3'd4
  } state_t;
`endif

  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

  state_t        state_r, state_s;
  logic [BW-1:0] baud_r, baud_s;
  logic [2:0]    bit_r, bit_s;
  logic [1:0]    byte_r, byte_s;
  logic [31:0]   shift_r, shift_s;
  logic [31:0]   hold_r, hold_s;
  logic          hold_valid_r, hold_valid_s;
  logic          txd_r, txd_s;
  logic          busy_r, busy_s;
  logic          word_done_r, word_done_s;
  logic          ready_r, ready_s;
  logic          xfer_s;
  logic          baud_end_s;
  logic          load_ok_s;
`ifdef P2S_PARITY_EN
  logic          parity_r, parity_s;
`endif

  assign baud_end_s    = (baud_r == BAUD_LAST);
  // ready_r mirrors !hold_valid_r, so a load is taken only into an empty holding register
  assign load_ok_s     = bus.load & ready_r;

  assign bus.ready     = ready_r;
  assign bus.txd       = txd_r;
  assign bus.busy      = busy_r;
  assign bus.word_done = word_done_r;

  // Next-state and next-output logic for the framing FSM and holding register
  always_comb begin
    state_s      = state_r;
    baud_s       = baud_r;
    bit_s        = bit_r;
    byte_s       = byte_r;
    shift_s      = shift_r;
    hold_s       = hold_r;
    hold_valid_s = hold_valid_r;
    txd_s        = txd_r;
    word_done_s  = 1'b0;
    xfer_s       = 1'b0;
`ifdef P2S_PARITY_EN
    parity_s     = parity_r;
`endif

    case (state_r)
      ST_IDLE: begin
        if (hold_valid_r) begin
          xfer_s = 1'b1;
        end else begin
          state_s = ST_IDLE;
          txd_s   = 1'b1;
        end
      end

      ST_START: begin
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          bit_s   = 3'd0;
          state_s = ST_DATA;
          txd_s   = shift_r[0];
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      ST_DATA: begin
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          // after eight shifts the next byte sits in shift_r[7:0]
          shift_s = {1'b0, shift_r[31:1]};
          if (bit_r == 3'd7) begin
            bit_s = 3'd0;
`ifdef P2S_PARITY_EN
            state_s = ST_PARITY;
            txd_s   = parity_r;
`else
            state_s = ST_STOP;
            txd_s   = 1'b1;
`endif
          end else begin
            bit_s = bit_r + 3'd1;
            txd_s = shift_r[1];
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

`ifdef P2S_PARITY_EN
      ST_PARITY: begin
        if (baud_end_s) begin
          baud_s  = BAUD_ZERO;
          state_s = ST_STOP;
          txd_s   = 1'b1;
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end
`endif

      ST_STOP: begin
        if (baud_end_s) begin
          baud_s = BAUD_ZERO;
          if (byte_r == 2'd3) begin
            word_done_s = 1'b1;
            byte_s      = 2'd0;
            if (hold_valid_r) begin
              xfer_s = 1'b1;
            end else begin
              state_s = ST_IDLE;
              txd_s   = 1'b1;
            end
          end else begin
            byte_s  = byte_r + 2'd1;
            state_s = ST_START;
            txd_s   = 1'b0;
`ifdef P2S_PARITY_EN
            parity_s = even_parity(shift_r[7:0]);
`endif
          end
        end else begin
          baud_s = baud_r + BAUD_ONE;
        end
      end

      default: begin
        state_s = ST_IDLE;
        baud_s  = BAUD_ZERO;
        bit_s   = 3'd0;
        byte_s  = 2'd0;
        txd_s   = 1'b1;
      end
    endcase

    // Transfer and capture are exclusive: capture needs an empty holding register
    if (xfer_s) begin
      shift_s      = hold_r;
      hold_valid_s = 1'b0;
      state_s      = ST_START;
      baud_s       = BAUD_ZERO;
      bit_s        = 3'd0;
      byte_s       = 2'd0;
      txd_s        = 1'b0;
`ifdef P2S_PARITY_EN
      parity_s     = even_parity(hold_r[7:0]);
`endif
    end else if (load_ok_s) begin
      hold_s       = bus.din;
      hold_valid_s = 1'b1;
    end else begin
      hold_s       = hold_r;
      hold_valid_s = hold_valid_r;
    end

    busy_s  = (state_s != ST_IDLE);
    ready_s = ~hold_valid_s;
  end

  // State, datapath and output registers with asynchronous reset to an idle line
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r      <= ST_IDLE;
      baud_r       <= BAUD_ZERO;
      bit_r        <= 3'd0;
      byte_r       <= 2'd0;
      shift_r      <= 32'd0;
      hold_r       <= 32'd0;
      hold_valid_r <= 1'b0;
      txd_r        <= 1'b1;
      busy_r       <= 1'b0;
      word_done_r  <= 1'b0;
      ready_r      <= 1'b1;
`ifdef P2S_PARITY_EN
      parity_r     <= 1'b0;
`endif
    end else begin
      state_r      <= state_s;
      baud_r       <= baud_s;
      bit_r        <= bit_s;
      byte_r       <= byte_s;
      shift_r      <= shift_s;
      hold_r       <= hold_s;
      hold_valid_r <= hold_valid_s;
      txd_r        <= txd_s;
      busy_r       <= busy_s;
      word_done_r  <= word_done_s;
      ready_r      <= ready_s;
`ifdef P2S_PARITY_EN
      parity_r     <= parity_s;
`endif
    end
  end

endmodule

// File: tb/tb_prng_p2s.sv
// tb_prng_p2s: scoreboard bench; a word-level model predicts ready/busy and the txd waveform.
module tb_prng_p2s;
  localparam int CPB = 4;
`ifdef P2S_PARITY_EN
  localparam int NBITS = 11;
  localparam bit PAR   = 1'b1;
`else
  localparam int NBITS = 10;
  localparam bit PAR   = 1'b0;
`endif
  localparam int WORD_CYC = 4 * NBITS * CPB;

  typedef struct {
    logic [31:0] data;
    bit          b2b;
  } item_t;

  logic clk = 1'b0;
  logic rst = 1'b0;
  prng_p2s_if bus();

  prng_p2s #(.CLKS_PER_BIT(CPB)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  item_t sb[$];
  int    checks     = 0;
  int    passes     = 0;
  int    remaining  = 0;
  bit    hold       = 1'b0;
  int    words_seen = 0;

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
  endtask

  task automatic chk32(input string name, input int act, input int exp);
    checks++;
    if (act === exp) passes++;
    else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
  endtask

  // Line level at cycle k of a word: start, 8 data bits LSB first, optional even parity, stop
  function automatic logic exp_bit(input logic [31:0] w, input int k);
    int         bt;
    int         by;
    int         p;
    logic [7:0] b;
    bt = k / CPB;
    by = bt / NBITS;
    p  = bt % NBITS;
    b  = w[by*8 +: 8];
    if (p == 0) return 1'b0;
    else if (p <= 8) return b[p-1];
    else if (PAR && p == 9) return ^b;
    else return 1'b1;
  endfunction

  // Word-level model: a word occupies the line for WORD_CYC cycles; one word may wait
  initial begin : model
    bit h0;
    forever begin
      @(posedge clk or posedge rst);
      if (rst) begin
        remaining = 0;
        hold      = 1'b0;
        sb.delete();
      end else begin
        h0 = hold;
        if (remaining > 0) remaining--;
        if (h0 && remaining == 0) begin
          remaining = WORD_CYC;
          hold      = 1'b0;
        end else if (bus.load && !h0) begin
          hold = 1'b1;
          sb.push_back('{data: bus.din, b2b: (remaining > 0)});
        end
      end
    end
  end

  // Monitor: per-cycle status checks and waveform comparison of each word on txd
  initial begin : monitor
    item_t cur;
    bit    active;
    bit    wd_pend;
    int    k;
    active  = 1'b0;
    wd_pend = 1'b0;
    k       = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        active  = 1'b0;
        wd_pend = 1'b0;
      end else begin
        chk1("ready", bus.ready, !hold);
        chk1("busy", bus.busy, remaining > 0);
        chk1("word_done", bus.word_done, wd_pend);
        if (!active && bus.txd == 1'b0) begin
          chk1("start_has_queued_word", sb.size() > 0, 1'b1);
          if (sb.size() > 0) begin
            cur    = sb.pop_front();
            chk1("gapless_start", wd_pend, cur.b2b);
            active = 1'b1;
            k      = 0;
          end
        end
        wd_pend = 1'b0;
        if (active) begin
          chk1("txd", bus.txd, exp_bit(cur.data, k));
          k++;
          if (k == WORD_CYC) begin
            active  = 1'b0;
            wd_pend = 1'b1;
            words_seen++;
          end
        end
      end
    end
  end

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_load(input logic [31:0] d);
    bus.load = 1'b1;
    bus.din  = d;
    @(negedge clk);
    bus.load = 1'b0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((remaining != 0 || hold) && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk1("idle_within_budget", n < 5000, 1'b1);
    cyc(4);
  endtask

  initial begin : stim
    int w0;
    bus.load = 1'b0;
    bus.din  = 32'd0;

    // asynchronous reset between clock edges
    #3 rst = 1'b1;
    #1;
    chk1("rst_ready", bus.ready, 1'b1);
    chk1("rst_txd", bus.txd, 1'b1);
    chk1("rst_busy", bus.busy, 1'b0);
    chk1("rst_word_done", bus.word_done, 1'b0);
    cyc(3);
    rst = 1'b0;
    cyc(3);

    // single word
    do_load(32'h000000A5);
    wait_idle();

    // back-to-back with a dropped third load
    w0 = words_seen;
    do_load(32'h12345678);
    cyc(20);
    do_load(32'hDEADBEEF);
    do_load(32'h11111111);
    wait_idle();
    chk32("b2b_word_count", words_seen - w0, 2);

    // parity pattern and din stability after capture
    do_load(32'h070000A5);
    wait_idle();
    bus.load = 1'b1;
    bus.din  = 32'h3C3C5AA5;
    @(negedge clk);
    bus.load = 1'b0;
    bus.din  = $urandom;
    cyc(3);
    bus.din  = $urandom;
    wait_idle();

    // randomized loads, many of them against a full holding register
    for (int i = 0; i < 700; i++) begin
      bus.load = ($urandom_range(0, 15) == 0);
      bus.din  = $urandom;
      @(negedge clk);
    end
    bus.load = 1'b0;
    wait_idle();

    // reset during the start bit of byte 2
    do_load(32'hCAFEF00D);
    cyc(82);
    @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk1("midword_rst_txd", bus.txd, 1'b1);
    chk1("midword_rst_ready", bus.ready, 1'b1);
    chk1("midword_rst_busy", bus.busy, 1'b0);
    cyc(2);
    rst = 1'b0;
    w0 = words_seen;
    cyc(250);
    chk32("no_words_after_rst", words_seen - w0, 0);
    chk1("line_idle_after_rst", bus.txd, 1'b1);

    chk32("scoreboard_empty", sb.size(), 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
